sonar_capture: RTL and testbench

Ultrasonic ranging front end that drives the sensor trigger, times the echo pulse and writes one result word per ping into a circular buffer in the dual-port data RAM through its second port. The processor reads results through the first port and polls `wr_ptr` to find the newest entry. The block is the only writer on RAM port 1.

---
 rtl/sonar_pkg.sv | 39 +++
 rtl/sonar_sync.sv | 28 ++
 rtl/sonar_capture.sv | 167 ++++++++++++++++
 tb/tb_sonar_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and result-word packing for the sonar capture block.
// Optional build macro SONAR_SEQ_TAG_EN adds a 7-bit ping sequence tag to each word.
package sonar_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_WRITE,
      S_HOLDOFF
   } state_t;

   localparam int TIMEOUT_BIT = 31;
   localparam int SEQ_MSB     = 30;
   localparam int SEQ_LSB     = 24;

`ifdef SONAR_SEQ_TAG_EN
   // Tagged format: width shrinks to 24 bits and saturates.
   function automatic logic [31:0] pack_result(input logic tout, input logic [30:0] width,
                                               input logic [6:0] seq);
      logic [31:0] w;
      w                  = '0;
      w[TIMEOUT_BIT]     = tout;
      w[SEQ_MSB:SEQ_LSB] = seq;
      w[SEQ_LSB-1:0]     = (|width[30:24]) ? '1 : width[23:0];
      return w;
   endfunction
`else
   function automatic logic [31:0] pack_result(input logic tout, input logic [30:0] width);
      logic [31:0] w;
      w                  = '0;
      w[TIMEOUT_BIT]     = tout;
      w[TIMEOUT_BIT-1:0] = width;
      return w;
   endfunction
`endif

endpackage

// File: rtl/sonar_sync.sv
// Two-flop synchronizer for the asynchronous echo pin, with rise/fall detect
// on the synchronized value.
module sonar_sync (
   input  logic clk,
   input  logic reset,
   input  logic echo_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= echo_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_capture.sv
// Ultrasonic ranging front end: triggers the sensor, times the echo and writes one
// result word per ping into a circular RAM buffer. Build macro: SONAR_SEQ_TAG_EN.
module sonar_capture
   import sonar_pkg::*;
#(
   parameter int                     DATA_WIDTH     = 32,
   parameter int                     ADDRESS_WIDTH  = 12,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR    = 12'hF00,
   parameter int                     BUF_DEPTH      = 64,
   parameter int                     TRIG_CYCLES    = 1000,
   parameter int                     TIMEOUT_CYCLES = 3_000_000,
   parameter int                     PERIOD_CYCLES  = 6_000_000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          echo,
   output logic                          trig,
   output logic                          wEn1,
   output logic [ADDRESS_WIDTH-1:0]      addr1,
   output logic [DATA_WIDTH-1:0]         dataIn1,
   output logic [$clog2(BUF_DEPTH)-1:0]  wr_ptr,
   output logic                          sample_valid,
   output logic                          busy
);

   localparam int PW = $clog2(BUF_DEPTH);

   state_t                   state_q, state_d;
   logic [31:0]              cnt_q, cnt_d, per_q, per_d;
   logic [30:0]              width_q, width_d;
   logic                     tout_q, tout_d;
   logic [PW-1:0]            wr_ptr_q;
   logic                     trig_q, trig_d, wen_q, wen_d, busy_q, busy_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     rise, fall;

   sonar_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .echo_i(echo),
      .rise_o(rise),
      .fall_o(fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         width_q <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         width_q <= width_d;
         tout_q  <= tout_d;
      end
   end

   // per_q counts from TRIG entry for the whole ping; cnt_q times TRIG and WAIT_RISE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 32'd1;
      per_d   = per_q + 32'd1;
      width_d = width_q;
      tout_d  = tout_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            per_d = '0;
            if (enable) state_d = S_TRIG;
         end
         S_TRIG: begin
            if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
               state_d = S_WAIT_RISE;
               cnt_d   = '0;
            end
         end
         S_WAIT_RISE: begin
            if (rise) begin
               state_d = S_MEASURE;
               width_d = 31'd1;
               tout_d  = 1'b0;
            end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_WRITE;
               width_d = '0;
               tout_d  = 1'b1;
            end
         end
         S_MEASURE: begin
            if (fall) begin
               state_d = S_WRITE;
            end else if (width_q == 31'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_WRITE;
               width_d = 31'(TIMEOUT_CYCLES);
               tout_d  = 1'b1;
            end else begin
               width_d = width_q + 31'd1;
            end
         end
         S_WRITE: state_d = S_HOLDOFF;
         S_HOLDOFF: begin
            if (per_q == 32'(PERIOD_CYCLES - 1)) begin
               state_d = enable ? S_TRIG : S_IDLE;
               per_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SONAR_SEQ_TAG_EN
   logic [6:0] seq_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  seq_q <= '0;
      else if (state_q == S_WRITE) seq_q <= seq_q + 7'd1;
   end
`endif

   // Outputs are decoded from the next state so they are registered yet aligned with it.
   always_comb begin
      trig_d = (state_d == S_TRIG);
      wen_d  = (state_d == S_WRITE);
      busy_d = (state_d != S_IDLE);
      addr_d = addr_q;
      data_d = data_q;
      if (wen_d) begin
         addr_d = BASE_ADDR + ADDRESS_WIDTH'(wr_ptr_q);
`ifdef SONAR_SEQ_TAG_EN
         data_d = DATA_WIDTH'(pack_result(tout_d, width_d, seq_q));
`else
         data_d = DATA_WIDTH'(pack_result(tout_d, width_d));
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_q   <= 1'b0;
         wen_q    <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= BASE_ADDR;
         data_q   <= '0;
         wr_ptr_q <= '0;
      end else begin
         trig_q <= trig_d;
         wen_q  <= wen_d;
         busy_q <= busy_d;
         addr_q <= addr_d;
         data_q <= data_d;
         if (state_q == S_WRITE) wr_ptr_q <= wr_ptr_q + PW'(1);
      end
   end

   assign trig         = trig_q;
   assign wEn1         = wen_q;
   assign sample_valid = wen_q;
   assign busy         = busy_q;
   assign addr1        = addr_q;
   assign dataIn1      = data_q;
   assign wr_ptr       = wr_ptr_q;

endmodule

// File: tb/tb_sonar_capture.sv
// Scoreboard bench for sonar_capture: expected words are queued when a ping is
// stimulated and checked when the DUT writes. Honors SONAR_SEQ_TAG_EN.
module tb_sonar_capture;

   localparam int TRIG = 4, TMO = 100, PER = 300, DEPTH = 4;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, echo = 1'b0;
   logic        trig, wEn1, sample_valid, busy;
   logic [11:0] addr1;
   logic [31:0] dataIn1;
   logic [1:0]  wr_ptr;

   sonar_capture #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(12'hF00), .BUF_DEPTH(DEPTH),
      .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .PERIOD_CYCLES(PER)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig), .wEn1(wEn1),
      .addr1(addr1), .dataIn1(dataIn1), .wr_ptr(wr_ptr), .sample_valid(sample_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0, n_err = 0;
   int          exp_ptr = 0, seq_m = 0, last_rise = -1, rise_cyc = 0;
   logic [31:0] tb_ram[DEPTH];
   logic [31:0] w50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Echo width may legitimately be off by one clock from the pin high time.
   function automatic logic [31:0] near(input logic [31:0] obs, input logic [31:0] exp);
      logic [31:0] d;
      d = obs - exp;
      return (d == 32'd0 || d == 32'd1 || d == 32'hFFFF_FFFF) ? exp : obs;
   endfunction

   function automatic logic [31:0] mk_word(input logic tout, input int w);
`ifdef SONAR_SEQ_TAG_EN
      return {tout, 7'(seq_m), 24'(w)};
`else
      return {tout, 31'(w)};
`endif
   endfunction

   task automatic push(input logic tout, input int w);
      exp_t e;
      e.addr = 12'hF00 + 12'(exp_ptr);
      e.data = mk_word(tout, w);
      exp_q.push_back(e);
      exp_ptr = (exp_ptr + 1) % DEPTH;
      seq_m   = (seq_m + 1) % 128;
   endtask

   always @(negedge clk) begin
      if (!reset && wEn1) begin
         chk("sample_valid", 32'(sample_valid), 32'd1);
         if (exp_q.size() == 0) chk("unexpected_write", 32'(wEn1), 32'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("addr1", 32'(addr1), 32'(e.addr));
            chk("dataIn1", near(dataIn1, e.data), e.data);
         end
         tb_ram[addr1[1:0]] = dataIn1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_trig();
      int n = 0, hi = 0;
      while (!trig && n < 400) begin step(); n++; end
      chk("trig_seen", 32'(trig), 32'd1);
      rise_cyc = cyc;
      if (last_rise >= 0) chk("trig_period", 32'(rise_cyc - last_rise), 32'(PER));
      last_rise = rise_cyc;
      while (trig && hi < 50) begin hi++; step(); end
      chk("trig_high", 32'(hi), 32'(TRIG));
   endtask

   task automatic wait_write();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin step(); n++; end
      chk("write_pending", 32'(exp_q.size()), 32'd0);
      chk("wr_ptr", 32'(wr_ptr), 32'(exp_ptr));
   endtask

   task automatic ping(input int w);
      push(1'b0, w);
      wait_trig();
      repeat (10) step();
      echo = 1'b1;
      repeat (w) step();
      echo = 1'b0;
      wait_write();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) step();
      chk("rst_trig", 32'(trig), 32'd0);
      chk("rst_wEn1", 32'(wEn1), 32'd0);
      chk("rst_addr1", 32'(addr1), 32'hF00);
      chk("rst_dataIn1", dataIn1, 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_sv", 32'(sample_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset  = 1'b0;
      step();
      enable = 1'b1;

      // normal ping
      ping(37);

      // no echo: WAIT_RISE timeout
      push(1'b1, 0);
      wait_trig();
      wait_write();

      // stuck echo across two pings
      echo = 1'b1;
      push(1'b1, 0);
      wait_trig();
      wait_write();
      push(1'b1, 0);
      wait_trig();
      wait_write();
      echo = 1'b0;

      // wrap through the 4-entry buffer
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) begin
            ping(50);
            w50 = mk_word(1'b0, 50);
         end else ping(10 * i);
      end
      // seq_m already advanced past the last ping, so rebuild the word with its tag
`ifdef SONAR_SEQ_TAG_EN
      w50 = {1'b0, 7'((seq_m + 127) % 128), 24'd50};
`endif
      chk("f00_final", near(tb_ram[0], w50), w50);

      // enable dropped mid-MEASURE: sample still written, then IDLE
      push(1'b0, 30);
      wait_trig();
      repeat (10) step();
      echo = 1'b1;
      repeat (15) step();
      enable = 1'b0;
      repeat (15) step();
      echo = 1'b0;
      wait_write();
      begin
         int n = 0;
         while (busy && n < 600) begin step(); n++; end
      end
      chk("busy_fall", 32'(cyc - rise_cyc), 32'(PER));
      repeat (20) step();
      chk("idle_trig", 32'(trig), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // reset mid-MEASURE
      last_rise = -1;
      enable    = 1'b1;
      wait_trig();
      repeat (10) step();
      echo = 1'b1;
      repeat (10) step();
      #2 reset = 1'b1;
      #1;
      chk("rstm_trig", 32'(trig), 32'd0);
      chk("rstm_wEn1", 32'(wEn1), 32'd0);
      chk("rstm_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rstm_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      echo   = 1'b0;
      repeat (5) step();
      reset   = 1'b0;
      exp_ptr = 0;
      seq_m   = 0;
      step();
      last_rise = -1;
      enable    = 1'b1;
      ping(20);
      enable = 1'b0;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
